debug_dump_unit: RTL and testbench
==================================

Name: debug_dump_unit

Overview:
- Hardware counterpart to the bench-side state printout of the pipelined CPU: it counts cycles, stalls and flushes, and on request streams a full state snapshot out over a valid/ready port.
- Snapshot contents: counters, PC, all 32 GPRs, and the first 8 data-memory words.
- Sits beside CPU; taps the hazard-detect stall/flush signals, a register-file debug read port and a byte-wide data-memory debug read port.

Parameters:
NUM_REGS, 32, register-file entries dumped
NUM_MEM_WORDS, 8, 32-bit data-memory words dumped (starting at byte 0x00)
CNT_W, 32, width of cycle/stall/flush counters

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous, active-low reset
stall_i  input  1  pipeline stall indication this cycle
flush_i  input  1  pipeline flush indication this cycle
pc_i  input  32  current PC
dump_req_i  input  1  start dump; sampled in IDLE only
reg_addr_o  output  5  register-file debug read address
reg_data_i  input  32  register-file read data, combinational from reg_addr_o
mem_addr_o  output  32  data-memory debug byte address
mem_byte_i  input  8  data-memory byte, combinational from mem_addr_o
dump_valid_o  output  1  stream word valid
dump_data_o  output  32  stream word
dump_last_o  output  1  final word of dump, qualified by valid
dump_ready_i  input  1  sink accepts word
busy_o  output  1  dump in progress
cycle_cnt_o  output  CNT_W  live cycle counter
stall_cnt_o  output  CNT_W  live stall counter
flush_cnt_o  output  CNT_W  live flush counter

Behaviour:
- Reset (async, rst_n_i=0): all outputs 0, FSM=IDLE, counters 0, snapshot regs 0. Takes effect immediately, including mid-dump.
- Counters run continuously, including during a dump, and wrap at 2^CNT_W:
  - cycle_cnt increments every rising edge.
  - stall_cnt increments when stall_i=1 and flush_i=0.
  - flush_cnt increments when flush_i=1.
- Stream order, item index 0..43:
  - 0 cycle, 1 stall, 2 flush, 3 PC (snapshot);
  - 4..35 R0..R31;
  - 36..43 M0..M7.
- Snapshot: when dump_req_i=1 in IDLE, the cycle/stall/flush counter values and pc_i present in that cycle are registered; the FSM goes to FETCH with item=0.
- FSM states: IDLE, FETCH, SEND.
  - IDLE: busy_o=0, valid=0.
  - FETCH, header item: load dump_data_o from snapshot; 1 cycle, then SEND.
  - FETCH, register item: reg_addr_o=item-4; capture reg_data_i at the edge; 1 cycle, then SEND.
  - FETCH, memory item: 4 cycles, byte_idx 0..3, mem_addr_o = 4*(item-36)+byte_idx. Bytes are assembled little-endian: word = {b3,b2,b1,b0}. Then SEND.
  - SEND: dump_valid_o=1. dump_data_o and dump_last_o are held stable while dump_ready_i=0. On valid&&ready, item++. If item was 43 (dump_last_o=1), go to IDLE; otherwise go to FETCH.
- Outside FETCH: reg_addr_o=0, mem_addr_o=0.
- busy_o=1 in FETCH and SEND.
- dump_req_i is ignored while busy. A request in the same cycle the last word handshakes is also ignored, because the FSM is not yet in IDLE.
- Timing with dump_ready_i held 1:
  - Each header/register word takes 2 cycles; each memory word takes 5.
  - busy_o is high for exactly 112 cycles.
  - First dump_valid_o is asserted 1 cycle after the request-accept edge.
- The register/memory value captured is whatever the read port presents during the FETCH cycle. The dump is not atomic against concurrent CPU writes.
- Reset deasserted mid-operation: the FSM resumes in IDLE. A partial dump is never resumed.

Test Plan:
1. Reset; over 20 cycles drive stall_i=1 alone for 3 cycles, stall_i=flush_i=1 for 1 cycle, flush_i=1 alone for 1 cycle -> stall_cnt_o=3, flush_cnt_o=2, cycle_cnt_o=20.
2. Reg model R9=10, R13=10, R15=20; memory bytes 4..7 = 0x0A,0,0,0; ready held 1; dump_req when cycle_cnt=25 -> exactly 44 words:
   - word0=25;
   - word13=10, word19=20;
   - word37=10;
   - dump_last_o only on word43;
   - busy_o high 112 cycles.
3. Memory bytes 0..3 = 0x05,0x00,0x00,0x80 -> word36=0x80000005; mem_addr_o sequences 0,1,2,3 during its FETCH.
4. Backpressure: ready=0 for 3 cycles while word5 is valid -> data/last stable across the stall, no word lost or duplicated, total still 44 words, busy 115 cycles.
5. dump_req_i pulsed during busy and on the last-word handshake cycle -> ignored. Live counters keep advancing while snapshot words 0..2 keep their request-time values.
6. rst_n_i asserted asynchronously at word 20 -> dump_valid_o and busy_o drop without a clock edge, counters read 0. After release, a new dump starts at item 0 with cycle word equal to the cycle count at the new request.

Source files
------------

// File: rtl/debug_dump_unit.sv
// debug_dump_unit: live cycle/stall/flush counters beside the CPU, plus a
// request-triggered snapshot dump (counters, PC, GPRs, low data memory)
// streamed out one 32-bit word at a time.
//
// Stream handshake: dump_valid_o rises when a word is ready and then holds,
// together with dump_data_o and dump_last_o, until the cycle where
// dump_ready_i is also 1. That cycle transfers the word. valid never
// depends on ready.
module debug_dump_unit #(
  parameter int NUM_REGS      = 32,
  parameter int NUM_MEM_WORDS = 8,
  parameter int CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      pc_i,
  input  logic             dump_req_i,
  output logic [4:0]       reg_addr_o,
  input  logic [31:0]      reg_data_i,
  output logic [31:0]      mem_addr_o,
  input  logic [7:0]       mem_byte_i,
  output logic             dump_valid_o,
  output logic [31:0]      dump_data_o,
  output logic             dump_last_o,
  input  logic             dump_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // Item map: 0..3 header (cycle, stall, flush, pc), then registers, then memory words.
  localparam int REG_BASE = 4;
  localparam int MEM_BASE = REG_BASE + NUM_REGS;
  localparam int LAST     = MEM_BASE + NUM_MEM_WORDS - 1;
  localparam int ITEM_W   = $clog2(LAST + 2);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  // Current FSM state is kept as a plain named signal so checkers can bind to it.
  state_t             state;
  state_t             next_state;
  logic [ITEM_W-1:0]  item;
  logic [1:0]         byte_idx;
  logic [CNT_W-1:0]   snap_cycle;
  logic [CNT_W-1:0]   snap_stall;
  logic [CNT_W-1:0]   snap_flush;
  logic [31:0]        snap_pc;
  logic [31:0]        hdr_word;
  logic [ITEM_W-1:0]  mem_word_idx;
  logic               is_hdr;
  logic               is_reg;
  logic               is_mem;

  assign is_hdr       = item < ITEM_W'(REG_BASE);
  assign is_reg       = !is_hdr && (item < ITEM_W'(MEM_BASE));
  assign is_mem       = !is_hdr && !is_reg;
  assign mem_word_idx = item - ITEM_W'(MEM_BASE);

  // State register; reset aborts any dump in progress.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic: header/register items fetch in one cycle, memory items in four.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (dump_req_i) next_state = FETCH;
      FETCH:   if (!is_mem || byte_idx == 2'd3) next_state = SEND;
      SEND:    if (dump_ready_i) next_state = (item == ITEM_W'(LAST)) ? IDLE : FETCH;
      default: next_state = IDLE;
    endcase
  end

  // Header word selected from the request-time snapshot.
  always_comb begin
    hdr_word = snap_pc;
    case (item[1:0])
      2'd0:    hdr_word = 32'(snap_cycle);
      2'd1:    hdr_word = 32'(snap_stall);
      2'd2:    hdr_word = 32'(snap_flush);
      default: hdr_word = snap_pc;
    endcase
  end

  // Counters, snapshot capture, item sequencing and word assembly.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cycle_cnt_o <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
      snap_cycle  <= '0;
      snap_stall  <= '0;
      snap_flush  <= '0;
      snap_pc     <= '0;
      item        <= '0;
      byte_idx    <= '0;
      dump_data_o <= '0;
    end else begin
      cycle_cnt_o <= cycle_cnt_o + 1'b1;
      // A flush outranks a simultaneous stall.
      if (flush_i)      flush_cnt_o <= flush_cnt_o + 1'b1;
      else if (stall_i) stall_cnt_o <= stall_cnt_o + 1'b1;
      case (state)
        IDLE: begin
          if (dump_req_i) begin
            snap_cycle <= cycle_cnt_o;
            snap_stall <= stall_cnt_o;
            snap_flush <= flush_cnt_o;
            snap_pc    <= pc_i;
            item       <= '0;
            byte_idx   <= '0;
          end
        end
        FETCH: begin
          if (is_hdr)      dump_data_o <= hdr_word;
          else if (is_reg) dump_data_o <= reg_data_i;
          else begin
            // Little-endian: byte 0 lands in bits 7:0; byte_idx wraps back to 0.
            dump_data_o[{byte_idx, 3'b000} +: 8] <= mem_byte_i;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        SEND: begin
          if (dump_ready_i) item <= item + ITEM_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake and debug read-port drive; read addresses are zero outside FETCH.
  always_comb begin
    busy_o       = (state != IDLE);
    dump_valid_o = (state == SEND);
    dump_last_o  = (state == SEND) && (item == ITEM_W'(LAST));
    reg_addr_o   = '0;
    mem_addr_o   = '0;
    if (state == FETCH && is_reg) reg_addr_o = 5'(item - ITEM_W'(REG_BASE));
    if (state == FETCH && is_mem) mem_addr_o = 32'(mem_word_idx) * 32'd4 + 32'(byte_idx);
  end

endmodule

// File: tb/tb_debug_dump_unit.sv
// Bench for debug_dump_unit: counter behaviour, full dumps with random
// register/memory contents, backpressure, ignored requests and async reset.
module tb_debug_dump_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] pc;
  logic        dump_req;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [31:0] mem_addr;
  logic [7:0]  mem_byte;
  logic        valid;
  logic [31:0] data;
  logic        last;
  logic        ready;
  logic        busy;
  logic [31:0] cycle_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  debug_dump_unit dut (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush), .pc_i(pc),
    .dump_req_i(dump_req), .reg_addr_o(reg_addr), .reg_data_i(reg_data),
    .mem_addr_o(mem_addr), .mem_byte_i(mem_byte), .dump_valid_o(valid),
    .dump_data_o(data), .dump_last_o(last), .dump_ready_i(ready), .busy_o(busy),
    .cycle_cnt_o(cycle_cnt), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  // Clock and read-port models.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] reg_model [32];
  logic [7:0]  mem_bytes [64];
  assign reg_data = reg_model[reg_addr];
  assign mem_byte = (mem_addr < 32'd64) ? mem_bytes[mem_addr[5:0]] : 8'h00;

  // Reference counters straight from the counting rules.
  logic [31:0] m_cycle, m_stall, m_flush;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cycle <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      m_cycle <= m_cycle + 1;
      if (flush)      m_flush <= m_flush + 1;
      else if (stall) m_stall <= m_stall + 1;
    end
  end

  logic [31:0] exp_q [$];
  logic [31:0] got [64];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pipe();
    stall = ($urandom_range(0, 3) == 0);
    flush = ($urandom_range(0, 7) == 0);
  endtask

  task automatic randomize_state();
    for (int i = 0; i < 32; i++) reg_model[i] = $urandom;
    for (int i = 0; i < 64; i++) mem_bytes[i] = 8'($urandom);
  endtask

  // Issue a request from IDLE and build the expected 44-word stream.
  task automatic start_dump();
    pc = $urandom;
    dump_req = 1'b1;
    exp_q.delete();
    exp_q.push_back(m_cycle);
    exp_q.push_back(m_stall);
    exp_q.push_back(m_flush);
    exp_q.push_back(pc);
    for (int r = 0; r < 32; r++) exp_q.push_back(reg_model[r]);
    for (int w = 0; w < 8; w++)
      exp_q.push_back({mem_bytes[4*w+3], mem_bytes[4*w+2], mem_bytes[4*w+1], mem_bytes[4*w]});
    tick();
    dump_req = 1'b0;
    check("busy_after_accept", busy, 1);
    check("no_valid_at_accept", valid, 0);
  endtask

  // Drive the sink until the dump ends; optional hold, request pulses, or async abort.
  task automatic run_dump(input int hold_at, input int hold_len, input bit pulse_req,
                          input int abort_at, output int busy_cyc, output int n_words);
    int held = 0;
    int guard = 0;
    bit first_seen = 0;
    logic [31:0] hold_data;
    logic        hold_last;
    logic [31:0] expw;
    logic [31:0] maddr_q [$];
    busy_cyc = 0;
    n_words  = 0;
    while (busy === 1'b1 && guard < 1000) begin
      guard++;
      rand_pipe();
      dump_req = (pulse_req && n_words == 10);
      if (abort_at >= 0 && n_words == abort_at && valid) begin
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 0);
        check("abort_cycle", cycle_cnt, 0);
        check("abort_stall", stall_cnt, 0);
        check("abort_flush", flush_cnt, 0);
        check("abort_data", data, 0);
        dump_req = 1'b0;
        return;
      end
      if (busy && !valid) begin
        if (n_words >= 4 && n_words < 36) check("reg_addr", reg_addr, n_words - 4);
        if (n_words == 36) maddr_q.push_back(mem_addr);
      end
      if (valid && !first_seen) begin
        first_seen = 1;
        check("first_valid_cycle", busy_cyc, 1);
      end
      if (valid && n_words == hold_at && held < hold_len) begin
        if (held == 0) begin
          hold_data = data;
          hold_last = last;
        end else begin
          check("hold_data", data, hold_data);
          check("hold_last", last, hold_last);
        end
        held++;
        ready = 1'b0;
      end else begin
        ready = 1'b1;
        if (valid) begin
          if (exp_q.size() == 0) begin
            check("word_count", n_words + 1, 44);
            expw = 32'h0;
          end else expw = exp_q.pop_front();
          if (n_words < 64) got[n_words] = data;
          check($sformatf("word%0d", n_words), data, expw);
          check($sformatf("last%0d", n_words), last, (n_words == 43));
          if (pulse_req && n_words == 43) dump_req = 1'b1;
          n_words++;
        end
      end
      busy_cyc++;
      tick();
    end
    dump_req = 1'b0;
    ready    = 1'b1;
    if (guard >= 1000) check("timeout", guard, 0);
    if (maddr_q.size() == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("mem_addr%0d", i), maddr_q[i], i);
    end else check("mem_addr_count", maddr_q.size(), 4);
  endtask

  int bc, nw;

  initial begin
    rst_n = 1'b0; stall = 0; flush = 0; dump_req = 0; ready = 1; pc = 0;
    randomize_state();
    #3;
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_last", last, 0);
    check("rst_data", data, 0);
    check("rst_cycle", cycle_cnt, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Counter rules over 20 cycles.
    stall = 1; flush = 0;
    repeat (3) tick();
    stall = 1; flush = 1; tick();
    stall = 0; flush = 1; tick();
    stall = 0; flush = 0;
    repeat (15) tick();
    check("t1_cycle", cycle_cnt, 20);
    check("t1_stall", stall_cnt, 3);
    check("t1_flush", flush_cnt, 2);

    // Full dump with known values, request at cycle 25.
    reg_model[9] = 10; reg_model[13] = 10; reg_model[15] = 20;
    mem_bytes[0] = 8'h05; mem_bytes[1] = 8'h00; mem_bytes[2] = 8'h00; mem_bytes[3] = 8'h80;
    mem_bytes[4] = 8'h0A; mem_bytes[5] = 8'h00; mem_bytes[6] = 8'h00; mem_bytes[7] = 8'h00;
    repeat (5) tick();
    check("t2_cycle_at_req", cycle_cnt, 25);
    start_dump();
    run_dump(-1, 0, 0, -1, bc, nw);
    check("t2_words", nw, 44);
    check("t2_busy", bc, 112);
    check("t2_word0", got[0], 25);
    check("t2_word13", got[13], 10);
    check("t2_word19", got[19], 20);
    check("t2_word36", got[36], 32'h80000005);
    check("t2_word37", got[37], 10);

    // Backpressure on word 5.
    randomize_state();
    tick();
    start_dump();
    run_dump(5, 3, 0, -1, bc, nw);
    check("t4_words", nw, 44);
    check("t4_busy", bc, 115);

    // Requests while busy and on the last handshake are ignored.
    randomize_state();
    repeat (3) tick();
    start_dump();
    run_dump(-1, 0, 1, -1, bc, nw);
    check("t5_words", nw, 44);
    check("t5_idle", busy, 0);
    tick();
    check("t5_still_idle", busy, 0);
    check("t5_no_valid", valid, 0);
    check("t5_live_cycle", cycle_cnt, m_cycle);
    check("t5_live_stall", stall_cnt, m_stall);
    check("t5_live_flush", flush_cnt, m_flush);
    check("t5_cycle_advanced", (cycle_cnt - got[0]) > 32'd100, 1);

    // Asynchronous reset mid-dump, then a fresh dump.
    randomize_state();
    tick();
    start_dump();
    run_dump(-1, 0, 0, 20, bc, nw);
    check("t6_abort_word", nw, 20);
    stall = 0; flush = 0;
    exp_q.delete();
    tick();
    check("t6_busy_in_reset", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) tick();
    start_dump();
    run_dump(-1, 0, 0, -1, bc, nw);
    check("t6_words", nw, 44);
    check("t6_busy", bc, 112);
    check("t6_word0", got[0], 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
